mp3_stream_ctrl: RTL and testbench

- Read-side sequencer for the byte FIFO that buffers MP3 data from storage.
- Pops FIFO words and hands them to the SPI byte transmitter feeding the MP3 decoder (SDI path).
- Sends in bursts of BURST_LEN bytes, gated by the decoder's DREQ line.
- Provides enable/pause control, a byte counter and a sticky underrun flag for the top-level player FSM.

---
 rtl/mp3_stream_ctrl.sv | 116 +++++++++++
 tb/tb_mp3_stream_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_stream_ctrl.sv
// Read-side sequencer: pops the MP3 byte FIFO and feeds the SDI SPI byte
// transmitter in DREQ-gated bursts, with pause control and status counters.
module mp3_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 32,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clr_status,
    input  logic                  dreq,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd,
    output logic                  spi_start,
    output logic [DATA_WIDTH-1:0] spi_data,
    input  logic                  spi_done,
    output logic                  busy,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  bytes_sent
);

    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DREQ,
        FETCH,
        SEND,
        WAIT_DONE
    } state_t;

    state_t         state;
    logic [BCW-1:0] burst_cnt;
    logic           dreq_m;
    logic           dreq_s;

    // The pop must be qualified by fifo_empty in the very cycle it is issued,
    // so it is decoded from the registered state rather than registered itself.
    assign fifo_rd = (state == FETCH) && enable && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            dreq_m     <= 1'b0;
            dreq_s     <= 1'b0;
            spi_start  <= 1'b0;
            spi_data   <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            bytes_sent <= '0;
        end else begin
            dreq_m    <= dreq;
            dreq_s    <= dreq_m;
            spi_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_DREQ;
                        busy  <= 1'b1;
                    end
                end
                WAIT_DREQ: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dreq_s) begin
                        burst_cnt <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fifo_empty) begin
                        underrun <= 1'b1;
                    end else begin
                        spi_data <= fifo_rdata;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    spi_start <= 1'b1;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (spi_done) begin
                        bytes_sent <= bytes_sent + CNT_WIDTH'(1);
                        if (burst_cnt == BURST_LAST || !enable) begin
                            state <= WAIT_DREQ;
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                            state     <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Status clear overrides any same-cycle increment or underrun set.
            if (clr_status) begin
                underrun   <= 1'b0;
                bytes_sent <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mp3_stream_ctrl.sv
// Self-checking bench for mp3_stream_ctrl with behavioural FIFO and SPI models.
module tb_mp3_stream_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clr_status = 1'b0;
    logic       dreq = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_done;
    logic       busy;
    logic       underrun;
    logic [3:0] bytes_sent;

    always #5 clk = ~clk;

    mp3_stream_ctrl #(
        .DATA_WIDTH(8),
        .BURST_LEN (4),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clr_status(clr_status),
        .dreq      (dreq),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd   (fifo_rd),
        .spi_start (spi_start),
        .spi_data  (spi_data),
        .spi_done  (spi_done),
        .busy      (busy),
        .underrun  (underrun),
        .bytes_sent(bytes_sent)
    );

    // FIFO model: writes come from the stimulus, pops from the DUT strobe.
    logic [7:0] mem [0:255];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr[7:0]];

    // SPI model: done pulse 8 cycles after start; logs every transmitted byte.
    logic       spi_done_m = 1'b0;
    logic       spi_done_x = 1'b0;
    int         spi_cnt = 0;
    logic [7:0] spi_lat = '0;
    logic [7:0] log_b [0:255];
    int log_n = 0;
    int start_cnt = 0;
    int pop_cnt = 0;
    int err_empty_rd = 0;
    int err_overlap = 0;
    int err_unstable = 0;
    assign spi_done = spi_done_m | spi_done_x;

    always @(posedge clk) begin
        spi_done_m <= 1'b0;
        if (fifo_rd && fifo_empty) err_empty_rd <= err_empty_rd + 1;
        if (fifo_rd && !fifo_empty) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (fifo_rd && spi_start) err_overlap <= err_overlap + 1;
        if (reset) begin
            spi_cnt <= 0;
        end else if (spi_start) begin
            spi_cnt              <= 8;
            spi_lat              <= spi_data;
            log_b[log_n[7:0]]    <= spi_data;
            log_n                <= log_n + 1;
            start_cnt            <= start_cnt + 1;
        end else if (spi_cnt != 0) begin
            if (spi_data != spi_lat) err_unstable <= err_unstable + 1;
            spi_cnt <= spi_cnt - 1;
            if (spi_cnt == 1) spi_done_m <= 1'b1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        dreq = 1'b0;
        clr_status = 1'b0;
        cycles(3);
        wr_ptr = rd_ptr;
        reset = 1'b0;
    endtask

    typedef struct {
        logic en;
        logic dr;
        int   nbytes;
        int   ncyc;
        logic exp_busy;
        int   exp_bytes;
        logic exp_under;
        int   exp_pops;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int pbase, lbase, sbase, k;
        bit seen;

        vecs[0] = '{1'b1, 1'b1, 4, 200, 1'b1, 4, 1'b1, 4};
        vecs[1] = '{1'b1, 1'b0, 4, 100, 1'b1, 0, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 4, 100, 1'b0, 0, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b1, 0,  50, 1'b1, 0, 1'b1, 0};
        vecs[4] = '{1'b1, 1'b1, 6, 250, 1'b1, 6, 1'b1, 6};
        vecs[5] = '{1'b1, 1'b1, 3, 200, 1'b1, 3, 1'b1, 3};

        // Reset state
        cycles(3);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_bytes", bytes_sent, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < vecs[i].nbytes; j++) push(8'(8'h80 + j));
            pbase = pop_cnt;
            enable = vecs[i].en;
            dreq = vecs[i].dr;
            cycles(vecs[i].ncyc);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_bytes", i), bytes_sent, vecs[i].exp_bytes);
            chk($sformatf("vec%0d_underrun", i), underrun, vecs[i].exp_under);
            chk($sformatf("vec%0d_pops", i), pop_cnt - pbase, vecs[i].exp_pops);
        end

        // Single burst, then waits for DREQ
        do_reset();
        for (int j = 1; j <= 64; j++) push(8'(j));
        pbase = pop_cnt;
        lbase = log_n;
        enable = 1'b1;
        dreq = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (fifo_rd) seen = 1;
        end
        chk("burst_first_rd_seen", seen, 1);
        dreq = 1'b0;
        cycles(100);
        chk("burst_pops", pop_cnt - pbase, 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("burst_byte%0d", j), log_b[8'(lbase + j)], j + 1);
        chk("burst_bytes", bytes_sent, 4);
        chk("burst_busy", busy, 1);
        chk("burst_underrun", underrun, 0);

        // DREQ gating and 3-cycle latency
        pbase = pop_cnt;
        cycles(100);
        chk("gate_no_pop", pop_cnt - pbase, 0);
        dreq = 1'b1;
        k = 0;
        for (int c = 1; c <= 10 && k == 0; c++) begin
            @(negedge clk);
            if (fifo_rd) k = c;
        end
        chk("gate_latency", k, 3);
        dreq = 1'b0;
        cycles(60);
        chk("gate_bytes", bytes_sent, 8);
        chk("gate_byte5", log_b[8'(lbase + 4)], 5);

        // Underrun: sticky across a later successful byte, cleared by clr_status
        do_reset();
        pbase = pop_cnt;
        enable = 1'b1;
        dreq = 1'b1;
        cycles(20);
        chk("under_set", underrun, 1);
        chk("under_no_pop", pop_cnt - pbase, 0);
        lbase = log_n;
        push(8'hA5);
        cycles(30);
        chk("under_byte", log_b[8'(lbase)], 8'hA5);
        chk("under_bytes", bytes_sent, 1);
        chk("under_sticky", underrun, 1);
        enable = 1'b0;
        cycles(3);
        chk("under_idle", busy, 0);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("under_clr_flag", underrun, 0);
        chk("under_clr_bytes", bytes_sent, 0);

        // Pause while byte 2 of 4 is on SPI
        do_reset();
        for (int j = 0; j < 8; j++) push(8'(8'h10 + j));
        pbase = pop_cnt;
        enable = 1'b1;
        dreq = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 2; c++) begin
            @(negedge clk);
            if (spi_start) k++;
        end
        chk("pause_second_start", k, 2);
        enable = 1'b0;
        cycles(30);
        chk("pause_pops", pop_cnt - pbase, 2);
        chk("pause_bytes", bytes_sent, 2);
        chk("pause_busy", busy, 0);
        chk("pause_head", fifo_rdata, 8'h12);

        // Stray spi_done outside WAIT_DONE is ignored
        spi_done_x = 1'b1;
        @(negedge clk);
        spi_done_x = 1'b0;
        cycles(2);
        chk("stray_done_bytes", bytes_sent, 2);

        // Counter wrap, then clear colliding with an increment
        do_reset();
        for (int j = 0; j < 17; j++) push(8'(8'h20 + j));
        pbase = pop_cnt;
        enable = 1'b1;
        dreq = 1'b1;
        cycles(400);
        chk("wrap_pops", pop_cnt - pbase, 17);
        chk("wrap_bytes", bytes_sent, 1);
        push(8'h55);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (spi_done_m) seen = 1;
        end
        chk("collide_done_seen", seen, 1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("collide_bytes", bytes_sent, 0);

        // Reset while in SEND
        do_reset();
        for (int j = 0; j < 4; j++) push(8'(8'hC0 + j));
        enable = 1'b1;
        dreq = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (fifo_rd) seen = 1;
        end
        chk("mid_rst_fetch_seen", seen, 1);
        @(negedge clk);
        chk("mid_rst_send_data", spi_data, 8'hC0);
        reset = 1'b1;
        @(negedge clk);
        sbase = start_cnt;
        pbase = pop_cnt;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_spi_start", spi_start, 0);
        chk("mid_rst_spi_data", spi_data, 0);
        chk("mid_rst_fifo_rd", fifo_rd, 0);
        chk("mid_rst_bytes", bytes_sent, 0);
        enable = 1'b0;
        dreq = 1'b0;
        reset = 1'b0;
        cycles(30);
        chk("mid_rst_no_start", start_cnt - sbase, 0);
        chk("mid_rst_no_pop", pop_cnt - pbase, 0);

        // Invariants observed over the whole run
        chk("inv_rd_while_empty", err_empty_rd, 0);
        chk("inv_rd_start_overlap", err_overlap, 0);
        chk("inv_spi_data_stable", err_unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
